// File: rtl/col_fifo_if.sv
// rtl/col_fifo_if.sv - producer/consumer handshake bundle for the column FIFO
interface col_fifo_if #(
    parameter int B      = 8,
    parameter int COLUMN = 3,
    parameter int W      = 2
);
    logic                       wr;
    logic                       rd;
    logic [COLUMN-1:0][B-1:0]   w_data;
    logic [COLUMN-1:0][B-1:0]   r_data;
    logic                       empty;
    logic                       full;
    logic                       almost_empty;
    logic                       almost_full;
    logic [W:0]                 level;
    logic                       wr_err;
    logic                       rd_err;

    modport master (
        output wr, rd, w_data,
        input  r_data, empty, full, almost_empty, almost_full, level, wr_err, rd_err
    );

    modport slave (
        input  wr, rd, w_data,
        output r_data, empty, full, almost_empty, almost_full, level, wr_err, rd_err
    );
endinterface

// File: rtl/col_fifo.sv
// rtl/col_fifo.sv - multi-lane show-ahead FIFO with level and thresholds; COL_FIFO_ERR_FLAGS_EN enables wr_err/rd_err
module col_fifo #(
    parameter int B      = 8,
    parameter int COLUMN = 3,
    parameter int W      = 2,
    parameter int AF_TH  = 2**W - 1,
    parameter int AE_TH  = 1
) (
    input  logic     clk,
    input  logic     reset,
    col_fifo_if.slave bus
);
    localparam int D = 2**W;
    localparam logic [W:0] FULL_LV = {1'b1, {W{1'b0}}};
    localparam logic [W:0] AF_LV   = AF_TH[W:0];
    localparam logic [W:0] AE_LV   = AE_TH[W:0];

    logic [COLUMN-1:0][B-1:0] mem [D];
    logic [W-1:0] w_ptr;
    logic [W-1:0] r_ptr;
    logic [W:0]   level;
    logic         empty_i;
    logic         full_i;
    logic         wr_ok;
    logic         rd_ok;
    logic [W:0]   level_next;

    assign empty_i = (level == '0);
    assign full_i  = (level == FULL_LV);

    // A full FIFO still takes a write when the same edge pops the head.
    assign wr_ok = bus.wr & (~full_i | bus.rd);
    assign rd_ok = bus.rd & ~empty_i;

    always_comb begin
        level_next = level;
        if (wr_ok & ~rd_ok)
            level_next = level + (W+1)'(1);
        else if (rd_ok & ~wr_ok)
            level_next = level - (W+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr <= '0;
            r_ptr <= '0;
            level <= '0;
        end else begin
            if (wr_ok)
                w_ptr <= w_ptr + W'(1);
            if (rd_ok)
                r_ptr <= r_ptr + W'(1);
            level <= level_next;
        end
    end

    // Storage is intentionally left uncleared by reset.
    always_ff @(posedge clk) begin
        if (wr_ok & ~reset)
            mem[w_ptr] <= bus.w_data;
    end

    assign bus.r_data       = mem[r_ptr];
    assign bus.level        = level;
    assign bus.empty        = empty_i;
    assign bus.full         = full_i;
    assign bus.almost_empty = (level <= AE_LV);
    assign bus.almost_full  = (level >= AF_LV);

`ifdef COL_FIFO_ERR_FLAGS_EN
    logic wr_err_q;
    logic rd_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            wr_err_q <= bus.wr & full_i & ~bus.rd;
            rd_err_q <= bus.rd & empty_i & ~bus.wr;
        end
    end

    assign bus.wr_err = wr_err_q;
    assign bus.rd_err = rd_err_q;
`else
    assign bus.wr_err = 1'b0;
    assign bus.rd_err = 1'b0;
`endif
endmodule
